spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
Upstream producer for fifo_buffer in the SPI flash read path. On a start pulse it drives an SPI mode-0 READ (0x03) transaction to the external flash: opcode, 24-bit address, then byte_count data bytes. Each received byte is pushed into the FIFO with a one-cycle write_req. SCLK is stretched low while the FIFO reports full, so no byte is lost or dropped.

Parameters:
CLK_DIV, 4, system_clk cycles per SCLK half-period (>=1)
ADDR_W, 24, flash address width (multiple of 8)
LEN_W, 16, width of byte_count
W, 8, data width pushed to the FIFO (matches fifo_buffer W)

Ports:
system_clk  in  1  system clock, all logic on its rising edge
system_reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request, accepted only when busy=0
start_addr  in  ADDR_W  flash byte address, latched on accepted start
byte_count  in  LEN_W  number of bytes to read, latched on accepted start
busy  out  1  high from accepted start until the done cycle, inclusive
done  out  1  one-cycle pulse when the transaction is complete
spi_cs_n  out  1  flash chip select, active low
spi_sclk  out  1  SPI clock, idles low (CPOL=0)
spi_mosi  out  1  command/address bits, MSB first
spi_miso  in  1  flash data, sampled on SCLK rising edge (CPHA=0)
fifo_full  in  1  fifo_buffer full flag
write_req  out  1  one-cycle push strobe to fifo_buffer
fifo_dataIn  out  W  byte to push, valid while write_req=1

Behaviour:
- Reset: spi_cs_n=1, spi_sclk=0, spi_mosi=0, write_req=0, fifo_dataIn=0, busy=0, done=0, state IDLE. Reset applies mid-transaction: on the next edge CS is deasserted, the transfer is abandoned, and no further write_req is issued.
- Tick: a divider counts CLK_DIV cycles. Each tick is one SCLK half-period. The divider runs only outside IDLE/DONE and is held cleared in WAIT_FIFO.
- States: IDLE -> CS_SETUP -> CMD -> ADDR -> DATA <-> WAIT_FIFO -> CS_HOLD -> DONE -> IDLE.
- IDLE: start with byte_count!=0 latches addr/count, sets busy, and asserts spi_cs_n=0. It also drives mosi with opcode bit 7 and goes to CS_SETUP.
- IDLE: start with byte_count==0 goes straight to DONE. CS is never asserted and write_req is never issued.
- IDLE: start while busy=1 is ignored.
- CS_SETUP: lasts one half-period with SCLK low, then the first rising edge occurs.
- CMD/ADDR: 8 + ADDR_W bits. The rising edge shifts nothing (flash samples). The falling edge updates mosi to the next bit. After the last address bit's falling edge, mosi=0 and the state goes to DATA.
- DATA: on each rising edge, shift spi_miso into an 8-bit register, MSB first.
- DATA: on the 8th rising edge, write_req=1 and fifo_dataIn=the assembled byte on the following cycle, for exactly one cycle. The remaining-byte counter decrements.
- DATA: after the following falling edge, if bytes remain, go to WAIT_FIFO if fifo_full=1 (SCLK held low, CS held low), otherwise continue. WAIT_FIFO returns to DATA on the cycle after fifo_full=0, with a fresh half-period before the next rising edge.
- fifo_full is never sampled in the same cycle as write_req. The check happens at least CLK_DIV cycles later, so the FIFO's updated full flag is seen.
- After the last byte's falling edge: CS_HOLD, one half-period with SCLK low. Then spi_cs_n=1 and the state goes to DONE.
- DONE: done=1 for one cycle, busy drops the following cycle, state returns to IDLE.
- SCLK only toggles in CMD/ADDR/DATA. It is always low when CS changes.
- byte_count=2^LEN_W-1 is legal. The 24-bit address wrap is handled by the flash, not by this block.

Decomposition:
- Package spi_flash_pkg holds: READ_CMD=8'h03, the state encoding (IDLE, CS_SETUP, CMD, ADDR, DATA, WAIT_FIFO, CS_HOLD, DONE), and default widths.
- Sub-module spi_sclk_gen holds the CLK_DIV counter. It emits rise_tick/fall_tick strobes and spi_sclk, with enable and clear inputs.

Test Plan:
- Reset mid-ADDR (assert system_reset during the 10th address bit) -> next edge spi_cs_n=1, spi_sclk=0, busy=0, no write_req afterwards. A following start works normally.
- CLK_DIV=2, start_addr=0x000100, byte_count=3, flash model returns A5,3C,FF, fifo_full=0 -> mosi stream 0x03,0x00,0x01,0x00. Exactly 56 SCLK rising edges, write_req pulses carry A5, 3C, FF in order, then a single done pulse after spi_cs_n=1.
- byte_count=0 -> done pulses two cycles after start; spi_cs_n stays 1; zero write_req.
- fifo_full forced 1 after first byte for 50 cycles, byte_count=2 -> spi_sclk held low and spi_cs_n low for the whole stall. The second byte is pushed only after full drops, and values are intact.
- start pulsed again while busy (during DATA) -> ignored; latched address and count unchanged; one done only.
- Back-to-back: connect fifo_buffer (D=4), read 6 bytes with the reader side draining 1 byte every 200 cycles -> no write_req while full=1; all 6 bytes are read out in order.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash read path: READ opcode, FSM encoding
// and the default widths used by the reader and its SCLK generator.
package spi_flash_pkg;

    localparam logic [7:0] READ_CMD = 8'h03;

    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_LEN_W   = 16;
    localparam int DEF_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        ADDR,
        DATA,
        WAIT_FIFO,
        CS_HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: emits a tick every CLK_DIV cycles while enabled
// and toggles spi_sclk on ticks when toggling is allowed (CPOL=0).
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic system_clk,
    input  logic system_reset,
    input  logic enable,
    input  logic clear,
    input  logic toggle_en,
    output logic tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic spi_sclk
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_comb begin
        tick      = enable && !clear && (cnt == CW'(CLK_DIV - 1));
        rise_tick = tick && toggle_en && !spi_sclk;
        fall_tick = tick && toggle_en && spi_sclk;
    end

    // Clearing also parks SCLK low so the line never idles high.
    always_ff @(posedge system_clk) begin
        if (system_reset || clear || !enable) begin
            cnt      <= '0;
            spi_sclk <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && toggle_en)
                spi_sclk <= !spi_sclk;
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03) master that streams received bytes into a FIFO,
// stretching SCLK low whenever the FIFO reports full.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int W       = DEF_W
) (
    input  logic              system_clk,
    input  logic              system_reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  byte_count,
    output logic              busy,
    output logic              done,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    input  logic              fifo_full,
    output logic              write_req,
    output logic [W-1:0]      fifo_dataIn
);

    localparam int SH_W  = 8 + ADDR_W;
    localparam int BC_W  = $clog2(SH_W);
    localparam int RXC_W = $clog2(W);

    state_t           state;
    logic [SH_W-1:0]  shreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [RXC_W-1:0] rx_cnt;
    logic [W-1:0]     rx_byte;
    logic [LEN_W-1:0] remaining;
    logic             byte_end;

    logic tick, rise_tick, fall_tick;
    logic gen_enable, gen_clear, gen_toggle;

    // The CS_SETUP tick is the first rising edge, so CS leads SCLK by one half-period.
    always_comb begin
        gen_enable = (state != IDLE) && (state != DONE);
        gen_clear  = (state == WAIT_FIFO);
        gen_toggle = state inside {CS_SETUP, CMD, ADDR, DATA};
    end

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .system_clk   (system_clk),
        .system_reset (system_reset),
        .enable       (gen_enable),
        .clear        (gen_clear),
        .toggle_en    (gen_toggle),
        .tick         (tick),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .spi_sclk     (spi_sclk)
    );

    // NOTE: every register here is a plain flop, so all are reset and assigned with <= only.
    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            state       <= IDLE;
            spi_cs_n    <= 1'b1;
            spi_mosi    <= 1'b0;
            write_req   <= 1'b0;
            fifo_dataIn <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            rx_cnt      <= '0;
            rx_byte     <= '0;
            remaining   <= '0;
            byte_end    <= 1'b0;
        end else begin
            write_req <= 1'b0;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start && !busy) begin
                        busy      <= 1'b1;
                        remaining <= byte_count;
                        if (byte_count == '0) begin
                            state <= DONE;
                        end else begin
                            shreg    <= {READ_CMD, start_addr};
                            spi_cs_n <= 1'b0;
                            spi_mosi <= READ_CMD[7];
                            bit_cnt  <= '0;
                            rx_cnt   <= '0;
                            byte_end <= 1'b0;
                            state    <= CS_SETUP;
                        end
                    end
                end
                CS_SETUP: begin
                    if (tick)
                        state <= CMD;
                end
                CMD, ADDR: begin
                    if (fall_tick) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BC_W'(SH_W - 1)) begin
                            spi_mosi <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                        end else begin
                            spi_mosi <= shreg[SH_W-2];
                            if (bit_cnt == BC_W'(7))
                                state <= ADDR;
                        end
                    end
                end
                DATA: begin
                    if (rise_tick) begin
                        rx_byte <= {rx_byte[W-2:0], spi_miso};
                        rx_cnt  <= rx_cnt + 1'b1;
                        if (rx_cnt == RXC_W'(W - 1)) begin
                            rx_cnt      <= '0;
                            write_req   <= 1'b1;
                            fifo_dataIn <= {rx_byte[W-2:0], spi_miso};
                            remaining   <= remaining - 1'b1;
                            byte_end    <= 1'b1;
                        end
                    end
                    // A full flag seen alongside our own push may be stale; park and re-check.
                    if (fall_tick && byte_end) begin
                        byte_end <= 1'b0;
                        if (remaining == '0)
                            state <= CS_HOLD;
                        else if (fifo_full || write_req)
                            state <= WAIT_FIFO;
                    end
                end
                WAIT_FIFO: begin
                    if (!fifo_full)
                        state <= DATA;
                end
                CS_HOLD: begin
                    if (tick) begin
                        spi_cs_n <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: behavioural SPI flash, a depth-4 FIFO
// model with slow drain, and hand-computed expectations for each scenario.
module tb_spi_flash_reader;

    localparam int CLK_DIV = 2;

    logic        system_clk   = 1'b0;
    logic        system_reset = 1'b1;
    logic        start        = 1'b0;
    logic [23:0] start_addr   = '0;
    logic [15:0] byte_count   = '0;
    logic        busy, done, spi_cs_n, spi_sclk, spi_mosi, write_req;
    logic        spi_miso     = 1'b0;
    logic        fifo_full;
    logic [7:0]  fifo_dataIn;

    int checks = 0;
    int errors = 0;

    always #5 system_clk = ~system_clk;

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .ADDR_W(24), .LEN_W(16), .W(8)) dut (
        .system_clk   (system_clk),
        .system_reset (system_reset),
        .start        (start),
        .start_addr   (start_addr),
        .byte_count   (byte_count),
        .busy         (busy),
        .done         (done),
        .spi_cs_n     (spi_cs_n),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .fifo_full    (fifo_full),
        .write_req    (write_req),
        .fifo_dataIn  (fifo_dataIn)
    );

    // Flash model: captures opcode+address on SCLK rise, drives data on SCLK fall.
    logic [7:0]  rd_data [0:7];
    int          f_bits      = 0;
    int          f_last_bits = 0;
    int          f_d         = 0;
    logic [31:0] f_cmd       = '0;
    logic        f_sclk_q    = 1'b0;
    logic        f_cs_q      = 1'b1;

    always @(negedge system_clk) begin
        if (spi_cs_n) begin
            if (!f_cs_q)
                f_last_bits = f_bits;
            f_bits = 0;
        end else if (spi_sclk && !f_sclk_q) begin
            if (f_bits < 32)
                f_cmd = {f_cmd[30:0], spi_mosi};
            f_bits++;
        end else if (!spi_sclk && f_sclk_q && f_bits >= 32) begin
            f_d = f_bits - 32;
            if (f_d < 64)
                spi_miso = rd_data[f_d / 8][7 - (f_d % 8)];
        end
        f_sclk_q = spi_sclk;
        f_cs_q   = spi_cs_n;
    end

    // Push log, done counter and depth-4 FIFO model with a slow reader.
    logic [7:0] wr_log [$];
    logic [7:0] ff_q   [$];
    logic [7:0] out_q  [$];
    int   done_cnt  = 0;
    int   cs_low    = 0;
    int   ovf       = 0;
    int   ff_count  = 0;
    int   drain_tmr = 0;
    logic ff_mode   = 1'b0;
    logic ff_force  = 1'b0;
    logic ff_fast   = 1'b0;

    assign fifo_full = ff_mode ? (ff_count >= 4) : ff_force;

    always @(negedge system_clk) begin
        if (write_req) begin
            wr_log.push_back(fifo_dataIn);
            if (ff_mode && ff_count >= 4)
                ovf++;
            else if (ff_mode)
                ff_q.push_back(fifo_dataIn);
        end
        if (done)
            done_cnt++;
        if (!spi_cs_n)
            cs_low++;
        if (ff_mode) begin
            drain_tmr++;
            if ((ff_fast || drain_tmr >= 200) && ff_q.size() > 0) begin
                out_q.push_back(ff_q.pop_front());
                drain_tmr = 0;
            end
        end
        ff_count = ff_q.size();
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge system_clk);
    endtask

    task automatic do_start(input logic [23:0] addr, input logic [15:0] cnt);
        start_addr = addr;
        byte_count = cnt;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        if (!done)
            check("done_timeout", done, 1);
    endtask

    function automatic logic [63:0] log_at(input int i);
        return (i < wr_log.size()) ? 64'(wr_log[i]) : 64'hBAD;
    endfunction

    function automatic logic [63:0] out_at(input int i);
        return (i < out_q.size()) ? 64'(out_q[i]) : 64'hBAD;
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        done_cnt = 0;
        cs_low   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int viol;
        int stall_wr;
        logic [7:0] exp6 [0:5];

        foreach (rd_data[i]) rd_data[i] = '0;

        // Reset state
        step(3);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_wr", write_req, 0);
        check("rst_data", fifo_dataIn, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        system_reset = 1'b0;
        step(2);

        // Basic 3-byte read
        rd_data[0] = 8'hA5; rd_data[1] = 8'h3C; rd_data[2] = 8'hFF;
        clear_logs();
        do_start(24'h000100, 16'd3);
        check("t1_busy", busy, 1);
        check("t1_cs", spi_cs_n, 0);
        wait_done(2000);
        check("t1_cs_at_done", spi_cs_n, 1);
        step(2);
        check("t1_busy_drop", busy, 0);
        check("t1_cmd", f_cmd, 32'h0300_0100);
        check("t1_rises", f_last_bits, 56);
        check("t1_nwr", wr_log.size(), 3);
        check("t1_b0", log_at(0), 8'hA5);
        check("t1_b1", log_at(1), 8'h3C);
        check("t1_b2", log_at(2), 8'hFF);
        check("t1_done_cnt", done_cnt, 1);

        // Zero-length request
        clear_logs();
        do_start(24'h000000, 16'd0);
        check("t2_done_c1", done, 0);
        check("t2_busy", busy, 1);
        step();
        check("t2_done_c2", done, 1);
        check("t2_cs", spi_cs_n, 1);
        step();
        check("t2_done_c3", done, 0);
        check("t2_busy_drop", busy, 0);
        step(20);
        check("t2_nwr", wr_log.size(), 0);
        check("t2_cs_low", cs_low, 0);
        check("t2_done_cnt", done_cnt, 1);

        // FIFO full stall after the first byte
        rd_data[0] = 8'h5A; rd_data[1] = 8'hC3;
        clear_logs();
        do_start(24'h000040, 16'd2);
        n = 0;
        while (!write_req && n < 1000) begin
            step();
            n++;
        end
        check("t3_first_wr", write_req, 1);
        ff_force = 1'b1;
        viol     = 0;
        stall_wr = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (i >= 2 && (spi_sclk || spi_cs_n))
                viol++;
            if (write_req)
                stall_wr++;
        end
        ff_force = 1'b0;
        check("t3_stall_viol", viol, 0);
        check("t3_stall_wr", stall_wr, 0);
        wait_done(1000);
        step(2);
        check("t3_nwr", wr_log.size(), 2);
        check("t3_b0", log_at(0), 8'h5A);
        check("t3_b1", log_at(1), 8'hC3);
        check("t3_done_cnt", done_cnt, 1);

        // Start while busy is ignored
        rd_data[0] = 8'h96; rd_data[1] = 8'h69;
        clear_logs();
        do_start(24'h123456, 16'd2);
        step(140);
        check("t4_busy", busy, 1);
        do_start(24'hABCDEF, 16'd5);
        wait_done(1000);
        step(20);
        check("t4_cmd", f_cmd, 32'h0312_3456);
        check("t4_rises", f_last_bits, 48);
        check("t4_nwr", wr_log.size(), 2);
        check("t4_b0", log_at(0), 8'h96);
        check("t4_b1", log_at(1), 8'h69);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_idle", busy, 0);

        // Reset during the 10th address bit
        clear_logs();
        do_start(24'h0F0F0F, 16'd4);
        n = 0;
        while (f_bits < 18 && n < 1000) begin
            step();
            n++;
        end
        check("t5_reached_addr", spi_cs_n, 0);
        system_reset = 1'b1;
        step();
        check("t5_cs_n", spi_cs_n, 1);
        check("t5_sclk", spi_sclk, 0);
        check("t5_busy", busy, 0);
        system_reset = 1'b0;
        stall_wr = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (write_req)
                stall_wr++;
        end
        check("t5_no_wr", stall_wr, 0);
        rd_data[0] = 8'h7E;
        clear_logs();
        do_start(24'h000010, 16'd1);
        wait_done(1000);
        step(2);
        check("t5_cmd", f_cmd, 32'h0300_0010);
        check("t5_nwr", wr_log.size(), 1);
        check("t5_b0", log_at(0), 8'h7E);

        // Back-to-back into a depth-4 FIFO with a slow reader
        exp6[0] = 8'h11; exp6[1] = 8'h22; exp6[2] = 8'h33;
        exp6[3] = 8'h44; exp6[4] = 8'h55; exp6[5] = 8'h66;
        for (int i = 0; i < 6; i++) rd_data[i] = exp6[i];
        clear_logs();
        ovf     = 0;
        ff_mode = 1'b1;
        do_start(24'h000200, 16'd6);
        wait_done(6000);
        ff_fast = 1'b1;
        n = 0;
        while (out_q.size() < 6 && n < 100) begin
            step();
            n++;
        end
        step(2);
        check("t6_ovf", ovf, 0);
        check("t6_nout", out_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t6_b%0d", i), out_at(i), exp6[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
